qam_demapper_ctrl_v2: RTL and testbench
=======================================

Name: qam_demapper_ctrl_v2

Overview:
Parametrised next-generation controller for the hard-decision QAM demapper output FIFO. It tracks FIFO occupancy internally instead of relying on external full/empty flags. It adds a programmable fill threshold, a choice between drop and backpressure when the FIFO is full, a sticky overflow flag with a saturating drop counter, and a FIFO clear strobe. It sits between the demapper symbol stream, the FIFO write/read enables and the host handshake.

Parameters:
DEPTH, 16, FIFO capacity in words (>=2)
AFULL_LVL, DEPTH, occupancy at which the block enters DATA_READY (1..DEPTH; out-of-range is an elaboration error)
MODE, 0, 0 = drop symbols while not receiving; 1 = backpressure via sym_ready
DROP_W, 8, width of the dropped-symbol counter
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
dclk  in  1  sole clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
enable  in  1  block enable; 0 forces IDLE on the next edge
sym_valid  in  1  demapper symbol present this cycle
read  in  1  host read request; one FIFO word per cycle while high
sym_ready  out  1  symbol will be accepted this cycle
write_enable  out  1  FIFO write strobe
read_enable  out  1  FIFO read strobe
fifo_clr  out  1  one-cycle FIFO clear pulse
level  out  CNT_W  current FIFO occupancy
available  out  1  data-available flag to the host
complete  out  1  transfer-complete flag to the host
overflow  out  1  sticky: at least one symbol dropped
drop_count  out  DROP_W  saturating count of dropped symbols
state  out  2  current state (00 IDLE, 01 RECEIVE, 10 DATA_READY, 11 READ_OUT)

Behaviour:
- Reset asserted (reset=0): state=IDLE, level=0, overflow=0, drop_count=0, fifo_clr=0. Combinational outputs then follow IDLE.
- available = (state==DATA_READY || state==READ_OUT). complete = !available. Both are decoded from the state register only.
- write_enable = sym_valid && state==RECEIVE && level<DEPTH (combinational).
- sym_ready = (state==RECEIVE && level<DEPTH) when MODE=1; constant 1 when MODE=0.
- read_enable = read && state==READ_OUT && level!=0 (combinational).
- level: +1 on write_enable, -1 on read_enable. The two strobes are never high together because they belong to different states. level stays within 0..DEPTH and never wraps.
- Drop, MODE=0 only: sym_valid while state is DATA_READY or READ_OUT is a drop. On each drop, drop_count increments and saturates at all-ones; overflow sets. MODE=1 never drops.
- Drop, any mode: sym_valid in IDLE is ignored and is not counted.
- Transitions (enable=0 overrides all, next edge -> IDLE):
  - IDLE -> RECEIVE when enable=1.
  - RECEIVE -> DATA_READY on the edge where level reaches AFULL_LVL, including the write in that cycle.
  - DATA_READY -> READ_OUT when read=1. No word is read in that cycle.
  - READ_OUT -> RECEIVE on the edge where level reaches 0. read=0 in READ_OUT holds the state.
- Entering IDLE from any other state: fifo_clr=1 for exactly one cycle (registered), level<=0, overflow<=0, drop_count<=0.
- Reset is asynchronous: asserting it mid-transfer clears everything immediately. fifo_clr is not pulsed on reset; the FIFO shares the same reset.
- Latency: the write_enable and read_enable strobes are in the same cycle as the request. level, available and complete update one edge later.
- read in RECEIVE or IDLE is ignored.

Test Plan:
1. DEPTH=16, AFULL_LVL=16, MODE=0; reset, enable=1, sym_valid=1 for 16 cycles -> 16 write_enable pulses, level=16, state=10, available=1, complete=0.
2. From scenario 1, read=1 continuously -> one cycle with no read_enable, then 16 read_enable pulses, level 16->0, state returns to 01, complete=1.
3. MODE=0, sym_valid held during DATA_READY for 300 cycles with DROP_W=8 -> overflow=1, drop_count saturates at 255. Then enable=0 -> fifo_clr pulses once, counters=0.
4. MODE=1, AFULL_LVL=8 -> sym_ready drops to 0 after the 8th write, no drops counted, state=10.
5. Assert reset=0 mid READ_OUT at level=5 -> immediately state=00, level=0, read_enable=0, available=0.
6. enable toggles to 0 in RECEIVE at level=3 -> next edge state=00, fifo_clr=1 for one cycle, level=0. Re-enable -> RECEIVE.

Source files
------------

// File: rtl/qam_demapper_ctrl_v2.sv
// Output-FIFO controller for the hard-decision QAM demapper: tracks occupancy,
// raises data-available at a programmable fill level, and drops or backpressures when busy.
module qam_demapper_ctrl_v2 #(
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = DEPTH,
   parameter int MODE      = 0,
   parameter int DROP_W    = 8,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic              dclk,
   input  logic              reset,
   input  logic              enable,
   input  logic              sym_valid,
   input  logic              read,
   output logic              sym_ready,
   output logic              write_enable,
   output logic              read_enable,
   output logic              fifo_clr,
   output logic [CNT_W-1:0]  level,
   output logic              available,
   output logic              complete,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count,
   output logic [1:0]        state
);

   if (DEPTH < 2 || AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_cfg
      $error("qam_demapper_ctrl_v2: DEPTH must be >= 2 and AFULL_LVL within 1..DEPTH");
   end

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      RECEIVE    = 2'b01,
      DATA_READY = 2'b10,
      READ_OUT   = 2'b11
   } state_t;

   state_t           st;
   logic             has_room;
   logic             drop;
   logic [CNT_W-1:0] lvl_nxt;

   assign state        = st;
   assign has_room     = (level < CNT_W'(DEPTH));
   assign write_enable = sym_valid && (st == RECEIVE) && has_room;
   assign read_enable  = read && (st == READ_OUT) && (level != '0);
   assign sym_ready    = (MODE != 0) ? ((st == RECEIVE) && has_room) : 1'b1;
   assign available    = (st == DATA_READY) || (st == READ_OUT);
   assign complete     = !available;
   assign drop         = (MODE == 0) && sym_valid && ((st == DATA_READY) || (st == READ_OUT));

   // Write and read strobes are mutually exclusive by state, so one adjust suffices.
   always_comb begin
      lvl_nxt = level;
      if (write_enable)
         lvl_nxt = level + CNT_W'(1);
      else if (read_enable)
         lvl_nxt = level - CNT_W'(1);
   end

   always_ff @(posedge dclk or negedge reset) begin
      if (!reset) begin
         st         <= IDLE;
         level      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
         fifo_clr   <= 1'b0;
      end else if (!enable) begin
         st         <= IDLE;
         level      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
         fifo_clr   <= (st != IDLE);
      end else begin
         fifo_clr <= 1'b0;
         level    <= lvl_nxt;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1)
               drop_count <= drop_count + DROP_W'(1);
         end
         case (st)
            IDLE:       st <= RECEIVE;
            RECEIVE:    if (lvl_nxt == CNT_W'(AFULL_LVL)) st <= DATA_READY;
            DATA_READY: if (read) st <= READ_OUT;
            READ_OUT:   if (lvl_nxt == '0) st <= RECEIVE;
            default:    st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qam_demapper_ctrl_v2.sv
// Randomised and directed bench for qam_demapper_ctrl_v2: two configurations share stimulus,
// a per-cycle expectation queue per instance is filled by the driver and drained by a monitor.
module tb_qam_demapper_ctrl_v2;

   logic dclk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic sym_valid = 1'b0;
   logic read = 1'b0;

   always #5 dclk = ~dclk;

   // Instance 0: DEPTH 16, threshold 16, drop mode, 8-bit drop counter
   logic       sr0, we0, re0, clr0, av0, cp0, ovf0;
   logic [4:0] lvl0;
   logic [7:0] dc0;
   logic [1:0] st0;
   // Instance 1: DEPTH 12, threshold 8, backpressure mode, 4-bit drop counter
   logic       sr1, we1, re1, clr1, av1, cp1, ovf1;
   logic [3:0] lvl1;
   logic [3:0] dc1;
   logic [1:0] st1;

   qam_demapper_ctrl_v2 #(.DEPTH(16), .AFULL_LVL(16), .MODE(0), .DROP_W(8)) dut0 (
      .dclk(dclk), .reset(reset), .enable(enable), .sym_valid(sym_valid), .read(read),
      .sym_ready(sr0), .write_enable(we0), .read_enable(re0), .fifo_clr(clr0),
      .level(lvl0), .available(av0), .complete(cp0), .overflow(ovf0),
      .drop_count(dc0), .state(st0));

   qam_demapper_ctrl_v2 #(.DEPTH(12), .AFULL_LVL(8), .MODE(1), .DROP_W(4)) dut1 (
      .dclk(dclk), .reset(reset), .enable(enable), .sym_valid(sym_valid), .read(read),
      .sym_ready(sr1), .write_enable(we1), .read_enable(re1), .fifo_clr(clr1),
      .level(lvl1), .available(av1), .complete(cp1), .overflow(ovf1),
      .drop_count(dc1), .state(st1));

   // Phase numbers follow the host-visible state code: 0 idle, 1 filling, 2 full, 3 draining.
   typedef struct {
      int phase;
      int occ;
      bit ovf;
      int drops;
      bit clr;
   } mdl_t;

   typedef struct {
      int st;
      int lvl;
      bit we, re, sr, av, cp, ovf, clr;
      int drops;
   } exp_t;

   int cfg_depth[2] = '{16, 12};
   int cfg_afull[2] = '{16, 8};
   int cfg_mode[2]  = '{0, 1};
   int cfg_dmax[2]  = '{255, 15};

   mdl_t m[2];
   exp_t q0[$];
   exp_t q1[$];
   int   passed = 0;
   int   total = 0;
   bit   in_rst = 1'b0, in_en = 1'b0, in_sv = 1'b0, in_rd = 1'b0;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.phase = 0; r.occ = 0; r.ovf = 0; r.drops = 0; r.clr = 0;
      return r;
   endfunction

   function automatic bit can_write(int k, mdl_t c, bit sv);
      return sv && c.phase == 1 && c.occ < cfg_depth[k];
   endfunction

   function automatic bit can_read(mdl_t c, bit rd);
      return rd && c.phase == 3 && c.occ > 0;
   endfunction

   function automatic mdl_t mdl_step(int k, mdl_t c, bit en, bit sv, bit rd);
      mdl_t n = c;
      n.clr = 0;
      if (!en) begin
         n = mdl_reset();
         n.clr = (c.phase != 0);
         return n;
      end
      if (can_write(k, c, sv)) n.occ++;
      if (can_read(c, rd))     n.occ--;
      if (cfg_mode[k] == 0 && sv && c.phase >= 2) begin
         n.ovf = 1;
         if (n.drops < cfg_dmax[k]) n.drops++;
      end
      case (c.phase)
         0: n.phase = 1;
         1: if (n.occ == cfg_afull[k]) n.phase = 2;
         2: if (rd) n.phase = 3;
         default: if (n.occ == 0) n.phase = 1;
      endcase
      return n;
   endfunction

   function automatic exp_t expect_of(int k, mdl_t c, bit sv, bit rd);
      exp_t e;
      e.st    = c.phase;
      e.lvl   = c.occ;
      e.we    = can_write(k, c, sv);
      e.re    = can_read(c, rd);
      e.sr    = (cfg_mode[k] == 0) ? 1'b1 : (c.phase == 1 && c.occ < cfg_depth[k]);
      e.av    = (c.phase >= 2);
      e.cp    = (c.phase < 2);
      e.ovf   = c.ovf;
      e.clr   = c.clr;
      e.drops = c.drops;
      return e;
   endfunction

   task automatic cycle(input bit r, input bit e, input bit s, input bit rd_i);
      @(posedge dclk);
      #1;
      for (int k = 0; k < 2; k++)
         m[k] = in_rst ? mdl_step(k, m[k], in_en, in_sv, in_rd) : mdl_reset();
      reset = r; enable = e; sym_valid = s; read = rd_i;
      in_rst = r; in_en = e; in_sv = s; in_rd = rd_i;
      if (!r) for (int k = 0; k < 2; k++) m[k] = mdl_reset();
      q0.push_back(expect_of(0, m[0], s, rd_i));
      q1.push_back(expect_of(1, m[1], s, rd_i));
   endtask

   task automatic drive(input bit r, input bit e, input bit s, input bit rd_i, input int n);
      for (int i = 0; i < n; i++) cycle(r, e, s, rd_i);
   endtask

   function automatic void chk(string name, int inst, int act, int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, inst, $time, act, req);
   endfunction

   always @(negedge dclk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         chk("state", 0, int'(st0), e.st);
         chk("level", 0, int'(lvl0), e.lvl);
         chk("write_enable", 0, int'(we0), int'(e.we));
         chk("read_enable", 0, int'(re0), int'(e.re));
         chk("sym_ready", 0, int'(sr0), int'(e.sr));
         chk("available", 0, int'(av0), int'(e.av));
         chk("complete", 0, int'(cp0), int'(e.cp));
         chk("overflow", 0, int'(ovf0), int'(e.ovf));
         chk("fifo_clr", 0, int'(clr0), int'(e.clr));
         chk("drop_count", 0, int'(dc0), e.drops);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         chk("state", 1, int'(st1), e.st);
         chk("level", 1, int'(lvl1), e.lvl);
         chk("write_enable", 1, int'(we1), int'(e.we));
         chk("read_enable", 1, int'(re1), int'(e.re));
         chk("sym_ready", 1, int'(sr1), int'(e.sr));
         chk("available", 1, int'(av1), int'(e.av));
         chk("complete", 1, int'(cp1), int'(e.cp));
         chk("overflow", 1, int'(ovf1), int'(e.ovf));
         chk("fifo_clr", 1, int'(clr1), int'(e.clr));
         chk("drop_count", 1, int'(dc1), e.drops);
      end
   end

   initial begin
      m[0] = mdl_reset();
      m[1] = mdl_reset();
      // Reset, then fill to the threshold
      drive(0, 0, 0, 0, 3);
      drive(1, 1, 1, 0, 20);
      // Continuous read drains to zero and returns to filling
      drive(1, 1, 0, 1, 20);
      // Refill, then hold sym_valid long enough to saturate the drop counter
      drive(1, 1, 1, 0, 320);
      drive(1, 0, 0, 0, 2);
      drive(1, 1, 0, 0, 2);
      // Reset asserted while draining at level 5
      drive(1, 1, 1, 0, 18);
      drive(1, 1, 0, 1, 12);
      drive(0, 1, 0, 1, 2);
      // Disable while filling at level 3, then re-enable
      drive(1, 1, 1, 0, 4);
      drive(1, 0, 0, 0, 2);
      drive(1, 1, 0, 0, 3);
      // Randomised traffic with occasional disable and reset
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 399) != 0, $urandom_range(0, 59) != 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      @(posedge dclk);
      @(negedge dclk);
      #1;
      total++;
      if (q0.size() == 0 && q1.size() == 0) passed++;
      else $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
